// File: rtl/isram_port_ctrl.sv
// rtl/isram_port_ctrl.sv - instruction SRAM port sequencer: round-robin dual reads, loader RUN/DRAIN/LOAD modes
module isram_port_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 192,
  parameter int NREQ   = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*DATA_W-1:0] rsp_data,
  input  logic                   load_en,
  output logic                   load_busy,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic                   sram_we,
  output logic [ADDR_W-1:0]      sram_waddr,
  output logic [DATA_W-1:0]      sram_wdata,
  output logic [ADDR_W-1:0]      sram_raddr1,
  output logic [ADDR_W-1:0]      sram_raddr2,
  input  logic [DATA_W-1:0]      sram_rdata1,
  input  logic [DATA_W-1:0]      sram_rdata2
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   hold_q, hold_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                   tag1_vld_q, tag1_vld_d;
  logic                   tag2_vld_q, tag2_vld_d;
  logic [IDW-1:0]         tag1_id_q, tag1_id_d;
  logic [IDW-1:0]         tag2_id_q, tag2_id_d;
  logic [ADDR_W-1:0]      raddr1_q, raddr1_d;
  logic [ADDR_W-1:0]      raddr2_q, raddr2_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NREQ*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [NREQ-1:0]        grant;
  logic                   pipe_empty;

  // Both read stages idle: no tagged address in flight and no response being presented
  assign pipe_empty = !tag1_vld_q && !tag2_vld_q && (rsp_valid_q == '0);

  // Mode sequencing; hold_d blocks reads for one cycle after LOAD so the last write lands first
  always_comb begin
    state_d = state_q;
    hold_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!load_en) state_d = ST_RUN;
        else if (pipe_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_d = ST_RUN;
          hold_d  = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Round-robin scan from rr_ptr: first valid requester to port 1, second to port 2
  always_comb begin
    int idx;
    int n;
    idx        = 0;
    n          = 0;
    grant      = '0;
    rr_ptr_d   = rr_ptr_q;
    tag1_vld_d = 1'b0;
    tag2_vld_d = 1'b0;
    tag1_id_d  = tag1_id_q;
    tag2_id_d  = tag2_id_q;
    raddr1_d   = raddr1_q;
    raddr2_d   = raddr2_q;
    if (state_q == ST_RUN && !load_en && !hold_q) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (req_valid[idx] && n < 2) begin
          grant[idx] = 1'b1;
          if (n == 0) begin
            tag1_vld_d = 1'b1;
            tag1_id_d  = IDW'(idx);
            raddr1_d   = req_addr[idx*ADDR_W +: ADDR_W];
          end else begin
            tag2_vld_d = 1'b1;
            tag2_id_d  = IDW'(idx);
            raddr2_d   = req_addr[idx*ADDR_W +: ADDR_W];
          end
          rr_ptr_d = (idx == NREQ - 1) ? '0 : IDW'(idx + 1);
          n = n + 1;
        end
      end
    end
  end

  // Second stage: capture async SRAM data into the tagged requester's slice and flag it
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag1_vld_q) begin
      rsp_valid_d[tag1_id_q] = 1'b1;
      rsp_data_d[int'(tag1_id_q)*DATA_W +: DATA_W] = sram_rdata1;
    end
    if (tag2_vld_q) begin
      rsp_valid_d[tag2_id_q] = 1'b1;
      rsp_data_d[int'(tag2_id_q)*DATA_W +: DATA_W] = sram_rdata2;
    end
  end

  // Loader write path: register a write only while the loader owns the SRAM
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (state_q == ST_LOAD && wr_valid) begin
      we_d    = 1'b1;
      waddr_d = wr_addr;
      wdata_d = wr_data;
    end
  end

  // State and pipeline registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      hold_q      <= 1'b0;
      rr_ptr_q    <= '0;
      tag1_vld_q  <= 1'b0;
      tag2_vld_q  <= 1'b0;
      tag1_id_q   <= '0;
      tag2_id_q   <= '0;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rr_ptr_q    <= rr_ptr_d;
      tag1_vld_q  <= tag1_vld_d;
      tag2_vld_q  <= tag2_vld_d;
      tag1_id_q   <= tag1_id_d;
      tag2_id_q   <= tag2_id_d;
      raddr1_q    <= raddr1_d;
      raddr2_q    <= raddr2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Grants are combinational; forced low while reset is asserted so every output reads 0
  assign req_ready   = grant & {NREQ{reset_n}};
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign load_busy   = (state_q != ST_RUN);
  assign wr_ready    = (state_q == ST_LOAD);
  assign sram_we     = we_q;
  assign sram_waddr  = waddr_q;
  assign sram_wdata  = wdata_q;
  assign sram_raddr1 = raddr1_q;
  assign sram_raddr2 = raddr2_q;

endmodule
